// File: rtl/game_io_hub.sv
// game_io_hub: kcpsm6 I/O hub for Tunnel Vision.
// Decodes processor port writes into display/game registers, muxes board
// inputs onto in_port, generates the level-dependent game tick and merges
// tick / collision / button edges into a masked, sticky, W1C interrupt status.
module game_io_hub #(
    parameter int         NUM_DIGITS = 4,
    parameter int         DIG_W      = 5,
    parameter int         CNT_W      = 26,
    parameter int         TICK_P0    = 10_000_000,
    parameter int         TICK_P1    = 4_000_000,
    parameter int         TICK_P2    = 2_000_000,
    parameter logic [7:0] VERSION    = 8'h02
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  db_btns,
    input  logic [7:0]                  db_sw,
    input  logic [1:0]                  randomized_value,
    input  logic                        collision_detect,
    input  logic [7:0]                  port_id,
    input  logic [7:0]                  out_port,
    input  logic                        write_strobe,
    input  logic                        k_write_strobe,
    input  logic                        read_strobe,
    input  logic                        interrupt_ack,
    output logic [7:0]                  in_port,
    output logic                        interrupt,
    output logic [7:0]                  led,
    output logic [NUM_DIGITS*DIG_W-1:0] dig_flat,
    output logic [NUM_DIGITS-1:0]       dp,
    output logic [7:0]                  game_info
);

    logic [7:0]                  led_q, game_info_q, status_q, mask_q, in_port_q;
    logic [NUM_DIGITS*DIG_W-1:0] dig_q;
    logic [NUM_DIGITS-1:0]       dp_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d, period_m1;
    logic [1:0]                  level, level_prev_q;
    logic                        coll_q, irq_q, irq_d, tick;
    logic [3:0]                  btns_q;
    logic [7:0]                  events, status_d, in_port_d;
    logic                        wr_status;

    // OUTPUTK and INPUT strobes carry no meaning here: reads have no side effects.
    logic unused_strobes;
    assign unused_strobes = k_write_strobe ^ read_strobe;

    assign level     = game_info_q[5:4];
    assign wr_status = write_strobe && (port_id == 8'h10);

    // Tick period for the current level (level 3 pauses and never uses it).
    always_comb begin
        case (level)
            2'd1:    period_m1 = CNT_W'(TICK_P1 - 1);
            2'd2:    period_m1 = CNT_W'(TICK_P2 - 1);
            default: period_m1 = CNT_W'(TICK_P0 - 1);
        endcase
    end

    // Tick counter next state: restart on level change, hold when paused, wrap with a tick.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (level != level_prev_q) begin
            cnt_d = '0;
        end else if (level != 2'd3) begin
            if (cnt_q == period_m1) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Event merge, sticky status with W1C (a new event beats a same-cycle clear), interrupt request.
    always_comb begin
        events   = {5'b0, |(db_btns & ~btns_q), collision_detect & ~coll_q, tick};
        status_d = (status_q & ~(wr_status ? out_port : 8'h00)) | events;
        if (|(events & mask_q))
            irq_d = 1'b1;
        else if (interrupt_ack)
            irq_d = 1'b0;
        else
            irq_d = irq_q;
    end

    // Read mux; registered every cycle regardless of read_strobe.
    always_comb begin
        case (port_id)
            8'h00:   in_port_d = {4'b0, db_btns};
            8'h01:   in_port_d = db_sw;
            8'h02:   in_port_d = {7'b0, collision_detect};
            8'h0F:   in_port_d = {6'b0, randomized_value};
            8'h10:   in_port_d = status_q;
            8'h11:   in_port_d = mask_q;
            8'h12:   in_port_d = {6'b0, level};
            8'h13:   in_port_d = VERSION;
            default: in_port_d = 8'h00;
        endcase
    end

    // Processor-writable registers. Digit ports count down from the leftmost digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q       <= 8'h00;
            dig_q       <= '0;
            dp_q        <= '0;
            game_info_q <= 8'h00;
            mask_q      <= 8'h01;
        end else if (write_strobe) begin
            if (port_id == 8'h02) led_q <= out_port;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (port_id == 8'(3 + k))
                    dig_q[(NUM_DIGITS-1-k)*DIG_W +: DIG_W] <= out_port[DIG_W-1:0];
            end
            if (port_id == 8'h07) dp_q        <= out_port[NUM_DIGITS-1:0];
            if (port_id == 8'h09) game_info_q <= out_port;
            if (port_id == 8'h11) mask_q      <= out_port;
        end
    end

    // Tick counter, edge-detect history, status, interrupt and read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            level_prev_q <= 2'd0;
            coll_q       <= 1'b0;
            btns_q       <= 4'h0;
            status_q     <= 8'h00;
            irq_q        <= 1'b0;
            in_port_q    <= 8'h00;
        end else begin
            cnt_q        <= cnt_d;
            level_prev_q <= level;
            coll_q       <= collision_detect;
            btns_q       <= db_btns;
            status_q     <= status_d;
            irq_q        <= irq_d;
            in_port_q    <= in_port_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;
    assign led       = led_q;
    assign dig_flat  = dig_q;
    assign dp        = dp_q;
    assign game_info = game_info_q;

endmodule

// File: tb/tb_game_io_hub.sv
// Directed bench for game_io_hub with short tick periods (10/4/6 clocks).
module tb_game_io_hub;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 5;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [3:0]                  db_btns;
    logic [7:0]                  db_sw;
    logic [1:0]                  randomized_value;
    logic                        collision_detect;
    logic [7:0]                  port_id;
    logic [7:0]                  out_port;
    logic                        write_strobe;
    logic                        k_write_strobe;
    logic                        read_strobe;
    logic                        interrupt_ack;
    logic [7:0]                  in_port;
    logic                        interrupt;
    logic [7:0]                  led;
    logic [NUM_DIGITS*DIG_W-1:0] dig_flat;
    logic [NUM_DIGITS-1:0]       dp;
    logic [7:0]                  game_info;

    int checks = 0;
    int errors = 0;

    game_io_hub #(
        .NUM_DIGITS(NUM_DIGITS), .DIG_W(DIG_W), .CNT_W(26),
        .TICK_P0(10), .TICK_P1(4), .TICK_P2(6), .VERSION(8'h02)
    ) dut (
        .clk(clk), .rst_n(rst_n), .db_btns(db_btns), .db_sw(db_sw),
        .randomized_value(randomized_value), .collision_detect(collision_detect),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
        .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
        .interrupt_ack(interrupt_ack), .in_port(in_port), .interrupt(interrupt),
        .led(led), .dig_flat(dig_flat), .dp(dp), .game_info(game_info)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] port;
        logic [3:0] btns;
        logic [7:0] sw;
        logic       coll;
        logic [1:0] rnd;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id      = p;
        out_port     = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p);
        port_id = p;
        step();
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        int hits;

        vecs[0]  = '{8'h00, 4'h5, 8'h00, 1'b0, 2'd0, 8'h05};
        vecs[1]  = '{8'h01, 4'h5, 8'hA5, 1'b0, 2'd0, 8'hA5};
        vecs[2]  = '{8'h01, 4'h5, 8'h3C, 1'b0, 2'd0, 8'h3C};
        vecs[3]  = '{8'h02, 4'h5, 8'h3C, 1'b1, 2'd0, 8'h01};
        vecs[4]  = '{8'h02, 4'h5, 8'h3C, 1'b0, 2'd0, 8'h00};
        vecs[5]  = '{8'h0F, 4'h5, 8'h3C, 1'b0, 2'd2, 8'h02};
        vecs[6]  = '{8'h0F, 4'h5, 8'h3C, 1'b0, 2'd1, 8'h01};
        vecs[7]  = '{8'h11, 4'h5, 8'h3C, 1'b0, 2'd1, 8'h04};
        vecs[8]  = '{8'h12, 4'h5, 8'h3C, 1'b0, 2'd1, 8'h03};
        vecs[9]  = '{8'h13, 4'h5, 8'h3C, 1'b0, 2'd1, 8'h02};
        vecs[10] = '{8'h20, 4'h5, 8'hFF, 1'b1, 2'd3, 8'h00};
        vecs[11] = '{8'h03, 4'h5, 8'hFF, 1'b0, 2'd3, 8'h00};

        rst_n = 1'b0; db_btns = 4'h0; db_sw = 8'h00; randomized_value = 2'd0;
        collision_detect = 1'b0; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;

        // Reset values
        step(); step();
        chk("rst_led", led, 8'h00);
        chk("rst_dig", dig_flat, 20'h0);
        chk("rst_dp", dp, 4'h0);
        chk("rst_game_info", game_info, 8'h00);
        chk("rst_irq", interrupt, 1'b0);
        chk("rst_in_port", in_port, 8'h00);
        rst_n = 1'b1;
        rd(8'h11); chk("rst_mask", in_port, 8'h01);
        rd(8'h13); chk("version", in_port, 8'h02);

        // Level 0 ticks every 10 clocks after a fresh reset
        rst_n = 1'b0; step(); rst_n = 1'b1;
        hits = 0;
        for (int i = 1; i <= 9; i++) begin step(); if (interrupt) hits++; end
        chk("tick0_early", hits, 0);
        step(); chk("tick0_at10", interrupt, 1'b1);
        port_id = 8'h10;
        ack(); chk("tick0_ack", interrupt, 1'b0);
        chk("status_tick", in_port, 8'h01);
        hits = 0;
        for (int i = 12; i <= 19; i++) begin step(); if (interrupt) hits++; end
        chk("tick0_gap", hits, 0);
        step(); chk("tick0_at20", interrupt, 1'b1);
        ack(); chk("tick0_ack2", interrupt, 1'b0);

        // Level 1 mid-count: counter restarts, tick 4 clocks after restart
        wr(8'h09, 8'h10);
        hits = 0;
        for (int i = 0; i < 4; i++) begin step(); if (interrupt) hits++; end
        chk("lvl1_early", hits, 0);
        step(); chk("lvl1_tick", interrupt, 1'b1);
        ack();

        // Level 3 pauses the counter
        wr(8'h09, 8'h30);
        hits = 0;
        for (int i = 0; i < 100; i++) begin step(); if (interrupt) hits++; end
        chk("paused_no_tick", hits, 0);

        // Tick arriving with the ack keeps the request up
        wr(8'h09, 8'h10);
        for (int i = 0; i < 4; i++) step();
        step(); chk("lvl1_tick_b", interrupt, 1'b1);
        for (int i = 0; i < 3; i++) step();
        interrupt_ack = 1'b1;
        step(); chk("tick_with_ack", interrupt, 1'b1);
        step(); chk("ack_after", interrupt, 1'b0);
        interrupt_ack = 1'b0;

        // Held collision gives a single event
        wr(8'h09, 8'h30);
        wr(8'h10, 8'hFF);
        wr(8'h11, 8'h02);
        collision_detect = 1'b1;
        step(); chk("coll_irq", interrupt, 1'b1);
        ack(); chk("coll_ack", interrupt, 1'b0);
        hits = 0;
        for (int i = 0; i < 48; i++) begin step(); if (interrupt) hits++; end
        chk("coll_held_once", hits, 0);
        rd(8'h10); chk("coll_status", in_port, 8'h02);
        collision_detect = 1'b0;
        wr(8'h10, 8'h02);
        rd(8'h10); chk("coll_w1c", in_port, 8'h00);

        // Masked button rise, set-beats-clear, unmasking a pending bit
        wr(8'h11, 8'h00);
        db_btns = 4'b0100;
        step(); step(); chk("btn_masked_irq", interrupt, 1'b0);
        rd(8'h10); chk("btn_status", in_port, 8'h04);
        db_btns = 4'b1100;
        wr(8'h10, 8'h04);
        rd(8'h10); chk("set_beats_w1c", in_port, 8'h04);
        wr(8'h11, 8'h04);
        step(); step(); chk("unmask_pending", interrupt, 1'b0);
        wr(8'h10, 8'h04);
        rd(8'h10); chk("btn_w1c", in_port, 8'h00);

        // Write decode
        wr(8'h04, 8'h15); chk("dig_wr04", dig_flat, 20'h05400);
        wr(8'h06, 8'h3F); chk("dig_wr06", dig_flat, 20'h0541F);
        wr(8'h02, 8'hA5); chk("led_wr", led, 8'hA5);
        wr(8'h07, 8'hFF); chk("dp_wr", dp, 4'hF);
        wr(8'h0A, 8'h77);
        chk("wr0A_led", led, 8'hA5);
        chk("wr0A_dig", dig_flat, 20'h0541F);
        chk("wr0A_dp", dp, 4'hF);
        chk("wr0A_game_info", game_info, 8'h30);
        port_id = 8'h02; out_port = 8'h00; k_write_strobe = 1'b1;
        step(); k_write_strobe = 1'b0;
        chk("outputk_ignored", led, 8'hA5);

        // Read mux table
        for (int i = 0; i < 12; i++) begin
            port_id          = vecs[i].port;
            db_btns          = vecs[i].btns;
            db_sw            = vecs[i].sw;
            collision_detect = vecs[i].coll;
            randomized_value = vecs[i].rnd;
            read_strobe      = i[0];
            step();
            chk($sformatf("rd_%02h_row%0d", vecs[i].port, i), in_port, vecs[i].exp);
        end
        read_strobe = 1'b0; collision_detect = 1'b0;

        // Reset mid-operation drops a pending interrupt
        db_btns = 4'h0; step();
        db_btns = 4'h1; step(); chk("pre_reset_irq", interrupt, 1'b1);
        rst_n = 1'b0; step();
        chk("midrst_irq", interrupt, 1'b0);
        chk("midrst_led", led, 8'h00);
        chk("midrst_dig", dig_flat, 20'h0);
        chk("midrst_dp", dp, 4'h0);
        chk("midrst_game_info", game_info, 8'h00);
        chk("midrst_in_port", in_port, 8'h00);
        rst_n = 1'b1;
        rd(8'h11); chk("midrst_mask", in_port, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
